rcc_test_clk_switch_ctrl: RTL and testbench

Sequencer that drives the select and gating side of the RCC test clock muxes, so that functional and test clocks are never swapped while downstream clocks are running. It takes an asynchronous scan request, gates all RCC-generated clocks, flips `testmode`, waits for the muxes to settle, re-enables the clocks and acknowledges. Exit from test mode runs the same sequence in reverse. It sits in the RCC always-on domain, in front of the per-clock test muxes.

---
 rtl/rcc_pkg.sv | 36 +++
 rtl/rcc_test_clk_switch_ctrl_if.sv | 19 +
 rtl/rcc_sync_2ff.sv | 23 ++
 rtl/rcc_test_clk_switch_ctrl.sv | 68 ++++++
 tb/tb_rcc_test_clk_switch_ctrl.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rcc_pkg.sv
// Shared types and constants for the RCC test-clock switch sequencer.
// State encoding is visible on state_o, so the values are fixed here.
package rcc_pkg;

    typedef enum logic [2:0] {
        ST_FUNC    = 3'd0,
        ST_OFF_IN  = 3'd1,
        ST_SW_IN   = 3'd2,
        ST_ON_IN   = 3'd3,
        ST_TEST    = 3'd4,
        ST_OFF_OUT = 3'd5,
        ST_SW_OUT  = 3'd6,
        ST_ON_OUT  = 3'd7
    } rcc_state_e;

    localparam int unsigned RCC_GATE_CYC_DEF   = 4;
    localparam int unsigned RCC_SETTLE_CYC_DEF = 8;

    typedef struct packed {
        logic testmode;
        logic clk_gate_en;
        logic scan_ack;
        logic busy;
    } rcc_out_t;

    // Output decode for a state; testmode only differs between states whose clk_gate_en is 0.
    function automatic rcc_out_t rcc_state_outputs(rcc_state_e st);
        rcc_out_t o;
        o.testmode    = (st == ST_SW_IN) || (st == ST_ON_IN) || (st == ST_TEST) || (st == ST_OFF_OUT);
        o.clk_gate_en = (st == ST_FUNC) || (st == ST_ON_IN) || (st == ST_TEST) || (st == ST_ON_OUT);
        o.scan_ack    = (st == ST_TEST);
        o.busy        = (st != ST_FUNC) && (st != ST_TEST);
        return o;
    endfunction

endpackage

// File: rtl/rcc_test_clk_switch_ctrl_if.sv
// Request/acknowledge and clock-control bundle between a scan requester and the sequencer.
interface rcc_test_clk_switch_ctrl_if;
    logic       scan_req;
    logic       testmode;
    logic       clk_gate_en;
    logic       scan_ack;
    logic       busy;
    logic [2:0] state_o;

    modport master (
        output scan_req,
        input  testmode, clk_gate_en, scan_ack, busy, state_o
    );

    modport slave (
        input  scan_req,
        output testmode, clk_gate_en, scan_ack, busy, state_o
    );
endinterface

// File: rtl/rcc_sync_2ff.sv
// Two-flop synchronizer for asynchronous RCC level inputs; resets to 0.
module rcc_sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/rcc_test_clk_switch_ctrl.sv
// Sequencer that gates RCC clocks, flips testmode, waits for mux settle and re-enables clocks.
// Entry and exit from test mode run mirrored sequences with a shared dwell counter.
module rcc_test_clk_switch_ctrl
    import rcc_pkg::*;
#(
    parameter int unsigned GATE_CYC   = RCC_GATE_CYC_DEF,
    parameter int unsigned SETTLE_CYC = RCC_SETTLE_CYC_DEF
) (
    input logic                       clk,
    input logic                       rst_n,
    rcc_test_clk_switch_ctrl_if.slave bus
);
    localparam logic [7:0] GATE_LOAD   = 8'(GATE_CYC - 1);
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYC - 1);
    localparam rcc_out_t   RESET_OUT   = rcc_state_outputs(ST_FUNC);

    logic       req_s;
    rcc_state_e state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    rcc_out_t   out_q, out_d;
    logic       dwell_done;

    rcc_sync_2ff u_req_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (bus.scan_req),
        .q_o   (req_s)
    );

    assign dwell_done = (cnt_q == 8'd0);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = dwell_done ? 8'd0 : cnt_q - 8'd1;
        unique case (state_q)
            ST_FUNC:    if (req_s)      begin state_d = ST_OFF_IN;  cnt_d = GATE_LOAD;   end
            ST_OFF_IN:  if (dwell_done) begin state_d = ST_SW_IN;   cnt_d = SETTLE_LOAD; end
            ST_SW_IN:   if (dwell_done) begin state_d = ST_ON_IN;   cnt_d = GATE_LOAD;   end
            ST_ON_IN:   if (dwell_done) begin state_d = ST_TEST;    cnt_d = 8'd0;        end
            ST_TEST:    if (!req_s)     begin state_d = ST_OFF_OUT; cnt_d = GATE_LOAD;   end
            ST_OFF_OUT: if (dwell_done) begin state_d = ST_SW_OUT;  cnt_d = SETTLE_LOAD; end
            ST_SW_OUT:  if (dwell_done) begin state_d = ST_ON_OUT;  cnt_d = GATE_LOAD;   end
            ST_ON_OUT:  if (dwell_done) begin state_d = ST_FUNC;    cnt_d = 8'd0;        end
            default:                    begin state_d = ST_FUNC;    cnt_d = 8'd0;        end
        endcase
        // Outputs are decoded from the next state so they change on the entering edge.
        out_d = rcc_state_outputs(state_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FUNC;
            cnt_q   <= 8'd0;
            out_q   <= RESET_OUT;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign bus.testmode    = out_q.testmode;
    assign bus.clk_gate_en = out_q.clk_gate_en;
    assign bus.scan_ack    = out_q.scan_ack;
    assign bus.busy        = out_q.busy;
    assign bus.state_o     = state_q;
endmodule

// File: tb/tb_rcc_test_clk_switch_ctrl.sv
// Bench for rcc_test_clk_switch_ctrl: a default instance for directed timing checks and a
// G=S=1 instance for random requests, both compared against a timeline reference model.
module tb_rcc_test_clk_switch_ctrl;

    localparam int GA = 4;
    localparam int SA = 8;
    localparam int GB = 1;
    localparam int SB = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    rcc_test_clk_switch_ctrl_if a_if ();
    rcc_test_clk_switch_ctrl_if b_if ();

    rcc_test_clk_switch_ctrl #(.GATE_CYC(GA), .SETTLE_CYC(SA)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a_if.slave)
    );

    rcc_test_clk_switch_ctrl #(.GATE_CYC(GB), .SETTLE_CYC(SB)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_if.slave)
    );

    // Reference model: synchronizer delay line, settled mode, and elapsed cycles of a running sequence.
    typedef struct {
        bit s1;
        bit s2;
        bit in_seq;
        bit dir;
        bit mode;
        int k;
    } model_t;

    typedef struct packed {
        logic       testmode;
        logic       gate;
        logic       ack;
        logic       busy;
        logic [2:0] state;
    } exp_t;

    model_t ma = '{default: 0};
    model_t mb = '{default: 0};
    int checks = 0;
    int errors = 0;
    logic pa_tm, pa_gate, pb_tm, pb_gate;

    function automatic model_t model_step(model_t m, bit req, int g, int s);
        model_t n = m;
        bit rs = m.s2;
        n.s2 = m.s1;
        n.s1 = req;
        if (!m.in_seq) begin
            if (rs != m.mode) begin
                n.in_seq = 1'b1;
                n.dir    = rs;
                n.k      = 0;
            end
        end else begin
            n.k = m.k + 1;
            if (n.k == 2 * g + s) begin
                n.in_seq = 1'b0;
                n.mode   = m.dir;
            end
        end
        return n;
    endfunction

    function automatic exp_t model_expect(model_t m, int g, int s);
        exp_t e;
        int phase;
        if (!m.in_seq) begin
            e.testmode = m.mode;
            e.gate     = 1'b1;
            e.ack      = m.mode;
            e.busy     = 1'b0;
            e.state    = m.mode ? 3'd4 : 3'd0;
        end else begin
            phase      = (m.k < g) ? 0 : (m.k < g + s) ? 1 : 2;
            e.testmode = m.dir ? (phase != 0) : (phase == 0);
            e.gate     = (phase == 2);
            e.ack      = 1'b0;
            e.busy     = 1'b1;
            e.state    = (m.dir ? 3'd1 : 3'd5) + 3'(phase);
        end
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma = '{default: 0};
            mb = '{default: 0};
        end else begin
            ma = model_step(ma, a_if.scan_req, GA, SA);
            mb = model_step(mb, b_if.scan_req, GB, SB);
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_inv(input string tag, input logic ptm, input logic pg,
                           input logic tm, input logic g);
        checks++;
        assert ((tm === ptm) || (pg === 1'b0 && g === 1'b0)) else begin
            errors++;
            $error("FAIL %s: testmode %0b->%0b with clk_gate_en %0b->%0b at %0t",
                   tag, ptm, tm, pg, g, $time);
        end
    endtask

    task automatic sync_prev();
        pa_tm   = a_if.testmode;
        pa_gate = a_if.clk_gate_en;
        pb_tm   = b_if.testmode;
        pb_gate = b_if.clk_gate_en;
    endtask

    // One clock: sample at the falling edge, compare both DUTs to the model and the invariant.
    task automatic tick();
        exp_t oa, ob;
        @(negedge clk);
        oa = '{a_if.testmode, a_if.clk_gate_en, a_if.scan_ack, a_if.busy, a_if.state_o};
        ob = '{b_if.testmode, b_if.clk_gate_en, b_if.scan_ack, b_if.busy, b_if.state_o};
        chk("model_a", 8'(oa), 8'(model_expect(ma, GA, SA)));
        chk("model_b", 8'(ob), 8'(model_expect(mb, GB, SB)));
        chk_inv("invariant_a", pa_tm, pa_gate, a_if.testmode, a_if.clk_gate_en);
        chk_inv("invariant_b", pb_tm, pb_gate, b_if.testmode, b_if.clk_gate_en);
        sync_prev();
    endtask

    task automatic wait_state_a(input string tag, input logic [2:0] st, input int budget);
        int n = 0;
        while (a_if.state_o !== st && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 8'(a_if.state_o), 8'(st));
    endtask

    initial begin
        int e_off, e_sw, e_on, e_ack, ack_cycles, hold;
        e_off = 3;
        e_sw  = 3 + GA;
        e_on  = 3 + GA + SA;
        e_ack = 3 + 2 * GA + SA;

        a_if.scan_req = 1'b0;
        b_if.scan_req = 1'b0;
        rst_n         = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_testmode", 8'(a_if.testmode), 8'd0);
        chk("rst_gate", 8'(a_if.clk_gate_en), 8'd1);
        chk("rst_ack", 8'(a_if.scan_ack), 8'd0);
        chk("rst_busy", 8'(a_if.busy), 8'd0);
        chk("rst_state", 8'(a_if.state_o), 8'd0);
        rst_n = 1'b1;
        sync_prev();
        repeat (2) tick();

        // Entry: edges counted from the request rising before edge 1.
        a_if.scan_req = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            chk("entry_gate", 8'(a_if.clk_gate_en), 8'(!(e >= e_off && e < e_on)));
            chk("entry_testmode", 8'(a_if.testmode), 8'(e >= e_sw));
            chk("entry_ack", 8'(a_if.scan_ack), 8'(e >= e_ack));
        end
        repeat (5) tick();

        // Exit mirrors entry from the falling request.
        a_if.scan_req = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            chk("exit_ack", 8'(a_if.scan_ack), 8'(e < e_off));
            chk("exit_testmode", 8'(a_if.testmode), 8'(e < e_sw));
            chk("exit_gate", 8'(a_if.clk_gate_en), 8'(!(e >= e_off && e < e_on)));
            chk("exit_busy", 8'(a_if.busy), 8'(e >= e_off && e < e_ack));
        end
        chk("exit_state", 8'(a_if.state_o), 8'd0);

        // Request dropped at the start of ON_IN: TEST is visited for exactly one cycle.
        a_if.scan_req = 1'b1;
        wait_state_a("reach_on_in", 3'd3, 40);
        a_if.scan_req = 1'b0;
        ack_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (a_if.scan_ack === 1'b1) ack_cycles++;
        end
        chk("on_in_drop_ack_cycles", 8'(ack_cycles), 8'd1);
        chk("on_in_drop_final_state", 8'(a_if.state_o), 8'd0);

        // Asynchronous reset while in SW_IN with testmode high.
        a_if.scan_req = 1'b1;
        wait_state_a("reach_sw_in", 3'd2, 40);
        chk("sw_in_testmode", 8'(a_if.testmode), 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_testmode", 8'(a_if.testmode), 8'd0);
        chk("async_rst_gate", 8'(a_if.clk_gate_en), 8'd1);
        chk("async_rst_state", 8'(a_if.state_o), 8'd0);
        chk("async_rst_busy", 8'(a_if.busy), 8'd0);
        a_if.scan_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sync_prev();
        repeat (3) tick();

        // Random request toggling on the G=S=1 instance.
        hold = 1;
        for (int i = 0; i < 3000; i++) begin
            tick();
            hold--;
            if (hold == 0) begin
                b_if.scan_req = 1'($urandom_range(0, 1));
                hold = int'($urandom_range(1, 8));
            end
        end
        b_if.scan_req = 1'b0;
        repeat (20) tick();
        chk("random_final_state", 8'(b_if.state_o), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
